// File: rtl/mult_fu_pipe_pkg.sv
// mult_fu_pipe_pkg: shared types and branch-resolve helper for the multiply FU
// Holds the function encoding, the branch mask type and the per-stage packet.
package mult_fu_pipe_pkg;
    localparam int XLEN_P = 32;
    localparam int B_MASK_W_P = 4;
    localparam int TAG_W_P = 6;
    localparam int DW = 2 * XLEN_P;
    typedef enum logic [1:0] {
        MULT_MUL    = 2'd0,
        MULT_MULH   = 2'd1,
        MULT_MULHSU = 2'd2,
        MULT_MULHU  = 2'd3
    } mult_func_t;
    typedef logic [B_MASK_W_P-1:0] b_mask_t;
    typedef struct packed {
        logic                 valid;
        logic [DW-1:0]        rs1_ext;
        logic [DW-1:0]        rs2_ext;
        logic [DW-1:0]        acc;
        mult_func_t           func;
        logic [TAG_W_P-1:0]   dest_tag;
        b_mask_t              b_mask;
    } mult_stage_packet_t;
    // A mispredict kills any op depending on the resolving branch; a correct
    // prediction just drops that branch from the op's mask.
    function automatic mult_stage_packet_t mult_resolve(input mult_stage_packet_t p, input b_mask_t res, input logic mis);
        mult_stage_packet_t r;
        r = p;
        r.valid = p.valid & ~(mis & (|(p.b_mask & res)));
        r.b_mask = mis ? p.b_mask : (p.b_mask & ~res);
        return r;
    endfunction
endpackage

// File: rtl/mult_fu_pipe_if.sv
// mult_fu_pipe_if: issue, CDB and branch-resolution bundle of the multiply FU
// master = issue/CDB side, slave = the functional unit.
interface mult_fu_pipe_if #(
    parameter int XLEN = 32,
    parameter int TAG_W = 6,
    parameter int B_MASK_W = 4
);
    logic                in_valid;
    logic [XLEN-1:0]     in_rs1;
    logic [XLEN-1:0]     in_rs2;
    logic [1:0]          in_func;
    logic [TAG_W-1:0]    in_dest_tag;
    logic [B_MASK_W-1:0] in_b_mask;
    logic                free;
    logic                cdb_early_valid;
    logic                cdb_valid;
    logic                cdb_gnt;
    logic [XLEN-1:0]     out_result;
    logic [TAG_W-1:0]    out_dest_tag;
    logic [B_MASK_W-1:0] out_b_mask;
    logic [B_MASK_W-1:0] b_mm_resolve;
    logic                b_mm_mispred;
    modport master (
        output in_valid, in_rs1, in_rs2, in_func, in_dest_tag, in_b_mask, cdb_gnt, b_mm_resolve, b_mm_mispred,
        input  free, cdb_early_valid, cdb_valid, out_result, out_dest_tag, out_b_mask
    );
    modport slave (
        input  in_valid, in_rs1, in_rs2, in_func, in_dest_tag, in_b_mask, cdb_gnt, b_mm_resolve, b_mm_mispred,
        output free, cdb_early_valid, cdb_valid, out_result, out_dest_tag, out_b_mask
    );
endinterface

// File: rtl/mult_fu_pipe_stage.sv
// mult_stage: one partial-product step of the multiply pipeline with branch squash
// Ports: clock/reset; ld loads the resolved upstream packet plus this stage's
// partial product, otherwise the held packet is kept with its mask resolved;
// q is the raw register, cur its view after this cycle's branch resolution.
module mult_stage
    import mult_fu_pipe_pkg::*;
#(
    parameter int K = 0,
    parameter int NUM_STAGES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ld,
    input  mult_stage_packet_t prev,
    input  b_mask_t            b_mm_resolve,
    input  logic               b_mm_mispred,
    output mult_stage_packet_t q,
    output mult_stage_packet_t cur
);
    localparam int C = DW / NUM_STAGES;
    mult_stage_packet_t up, nxt;
    always_comb begin
        up = mult_resolve(prev, b_mm_resolve, b_mm_mispred);
        nxt = up;
        nxt.acc = up.acc + ((up.rs1_ext * DW'(up.rs2_ext[K*C +: C])) << (K * C));
    end
    assign cur = mult_resolve(q, b_mm_resolve, b_mm_mispred);
    always_ff @(posedge clock) begin
        if (reset) q <= '0;
        else q <= ld ? nxt : cur;
    end
endmodule

// File: rtl/mult_fu_pipe.sv
// mult_fu_pipe: pipelined RV32M multiply unit with branch squash and CDB backpressure
// Ports: clock, reset (sync, active-high); io (mult_fu_pipe_if.slave) carries
// issue (in_*, free), CDB (cdb_*, out_*) and branch resolution (b_mm_*).
// MULT_BUBBLE_COLLAPSE_EN: per-stage ready so bubbles collapse behind a stalled
// final stage; otherwise the whole pipe freezes while the CDB withholds grant.
module mult_fu_pipe
    import mult_fu_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NUM_STAGES = 4,
    parameter int B_MASK_W = 4,
    parameter int TAG_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    mult_fu_pipe_if.slave   io
);
    mult_func_t              func_in;
    mult_stage_packet_t      in_pkt;
    mult_stage_packet_t      prev [NUM_STAGES];
    mult_stage_packet_t      q    [NUM_STAGES];
    mult_stage_packet_t      cur  [NUM_STAGES];
    logic [NUM_STAGES-1:0]   ld;
    assign func_in = mult_func_t'(io.in_func);
    always_comb begin
        in_pkt.valid = io.in_valid;
        in_pkt.rs1_ext = (func_in != MULT_MULHU) ? DW'($signed(io.in_rs1)) : DW'(io.in_rs1);
        in_pkt.rs2_ext = (func_in == MULT_MUL || func_in == MULT_MULH) ? DW'($signed(io.in_rs2)) : DW'(io.in_rs2);
        in_pkt.acc = '0;
        in_pkt.func = func_in;
        in_pkt.dest_tag = io.in_dest_tag;
        in_pkt.b_mask = io.in_b_mask;
    end
`ifdef MULT_BUBBLE_COLLAPSE_EN
    // A stage may load whenever its current content leaves or is dead.
    always_comb begin
        ld[NUM_STAGES-1] = ~cur[NUM_STAGES-1].valid | io.cdb_gnt;
        for (int i = NUM_STAGES - 2; i >= 0; i--) ld[i] = ~cur[i].valid | ld[i+1];
    end
`else
    assign ld = {NUM_STAGES{~(cur[NUM_STAGES-1].valid & ~io.cdb_gnt)}};
`endif
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign prev[k] = in_pkt;
        end else begin : g_body
            assign prev[k] = q[k-1];
        end
        mult_stage #(.K(k), .NUM_STAGES(NUM_STAGES)) u_stage (
            .clock        (clock),
            .reset        (reset),
            .ld           (ld[k]),
            .prev         (prev[k]),
            .b_mm_resolve (io.b_mm_resolve),
            .b_mm_mispred (io.b_mm_mispred),
            .q            (q[k]),
            .cur          (cur[k])
        );
    end
    assign io.free = ld[0];
    assign io.cdb_valid = cur[NUM_STAGES-1].valid;
    assign io.cdb_early_valid = cur[NUM_STAGES-2].valid;
    assign io.out_result = XLEN'((q[NUM_STAGES-1].func == MULT_MUL) ? q[NUM_STAGES-1].acc : (q[NUM_STAGES-1].acc >> XLEN));
    assign io.out_dest_tag = TAG_W'(cur[NUM_STAGES-1].dest_tag);
    assign io.out_b_mask = B_MASK_W'(cur[NUM_STAGES-1].b_mask);
endmodule

// File: tb/tb_mult_fu_pipe.sv
// tb_mult_fu_pipe: directed and randomized checks of mult_fu_pipe against a scoreboard
module tb_mult_fu_pipe;
    localparam int N = 4;
    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  tag;
        logic [3:0]  mask;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t sb [$];
    always #5 clock = ~clock;
    mult_fu_pipe_if #(.XLEN(32), .TAG_W(6), .B_MASK_W(4)) io ();
    mult_fu_pipe #(.XLEN(32), .NUM_STAGES(N), .B_MASK_W(4), .TAG_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] sa;
        logic signed [32:0] sb2;
        logic signed [65:0] p;
        sa = (f != 2'd3) ? $signed({a[31], a}) : $signed({1'b0, a});
        sb2 = (f <= 2'd1) ? $signed({b[31], b}) : $signed({1'b0, b});
        p = 66'(sa) * 66'(sb2);
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic drive(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tg, input logic [3:0] m);
        io.in_valid = 1'b1;
        io.in_func = f;
        io.in_rs1 = a;
        io.in_rs2 = b;
        io.in_dest_tag = tg;
        io.in_b_mask = m;
    endtask
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tg, input logic [31:0] exp);
        int lat;
        int early_at;
        lat = -1;
        early_at = -1;
        io.cdb_gnt = 1'b1;
        drive(f, a, b, tg, 4'b0);
        tick();
        io.in_valid = 1'b0;
        for (int n = 0; n < 12 && lat < 0; n++) begin
            @(negedge clock);
            if (io.cdb_valid) begin
                lat = n;
                check("op_result", io.out_result, exp);
                check("op_tag", io.out_dest_tag, tg);
            end else if (io.cdb_early_valid) early_at = n;
            tick();
        end
        check("op_latency", lat, N - 1);
        check("op_early", early_at, N - 2);
    endtask
    // Reference: in-order list of expected results; branch resolution is
    // applied to every pending entry and to the op being offered.
    always @(negedge clock) begin : scoreboard
        exp_t keep [$];
        exp_t e;
        if (reset) sb.delete();
        else begin
            keep.delete();
            foreach (sb[i]) begin
                e = sb[i];
                if (!(io.b_mm_mispred && (e.mask & io.b_mm_resolve) != 4'b0)) begin
                    if (!io.b_mm_mispred) e.mask = e.mask & ~io.b_mm_resolve;
                    keep.push_back(e);
                end
            end
            sb = keep;
            if (io.cdb_valid) begin
                check("sb_pending", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("sb_result", io.out_result, sb[0].res);
                    check("sb_tag", io.out_dest_tag, sb[0].tag);
                    check("sb_mask", io.out_b_mask, sb[0].mask);
                    if (io.cdb_gnt) void'(sb.pop_front());
                end
            end
`ifndef MULT_BUBBLE_COLLAPSE_EN
            check("free_rule", io.free, !(io.cdb_valid && !io.cdb_gnt));
`endif
            if (io.in_valid && io.free && !(io.b_mm_mispred && (io.in_b_mask & io.b_mm_resolve) != 4'b0))
                sb.push_back('{ref_mul(io.in_func, io.in_rs1, io.in_rs2), io.in_dest_tag,
                               io.b_mm_mispred ? io.in_b_mask : (io.in_b_mask & ~io.b_mm_resolve)});
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
    initial begin
        logic [31:0] stall_exp [3];
        int sx, sy, lat;
        logic [31:0] yr;
        stall_exp = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF};
        io.in_valid = 1'b0;
        io.in_rs1 = '0;
        io.in_rs2 = '0;
        io.in_func = '0;
        io.in_dest_tag = '0;
        io.in_b_mask = '0;
        io.cdb_gnt = 1'b0;
        io.b_mm_resolve = '0;
        io.b_mm_mispred = 1'b0;
        tick();
        tick();
        @(negedge clock);
        check("rst_free", io.free, 1);
        check("rst_cdb_valid", io.cdb_valid, 0);
        check("rst_early", io.cdb_early_valid, 0);
        check("rst_result", io.out_result, 0);
        check("rst_tag", io.out_dest_tag, 0);
        check("rst_mask", io.out_b_mask, 0);
        tick();
        reset = 1'b0;
        run_op(2'd0, 32'd7, 32'hFFFF_FFFD, 6'd5, 32'hFFFF_FFEB);
        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1, 32'hFFFF_FFFE);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 32'h0);
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3, 32'hFFFF_FFFF);
        io.cdb_gnt = 1'b0;
        drive(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd10, 4'b0);
        tick();
        drive(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd11, 4'b0);
        tick();
        drive(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd12, 4'b0);
        tick();
        io.in_valid = 1'b0;
        tick();
        repeat (3) begin
            @(negedge clock);
            check("stall_valid", io.cdb_valid, 1);
            check("stall_result", io.out_result, 32'hFFFF_FFFE);
`ifndef MULT_BUBBLE_COLLAPSE_EN
            check("stall_free", io.free, 0);
`endif
            tick();
        end
        io.cdb_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("unstall_valid", io.cdb_valid, 1);
            check("unstall_tag", io.out_dest_tag, 10 + i);
            check("unstall_result", io.out_result, stall_exp[i]);
            tick();
        end
        drive(2'd0, 32'd3, 32'd5, 6'd20, 4'b0010);
        tick();
        drive(2'd0, 32'd6, 32'd7, 6'd21, 4'b0001);
        tick();
        io.in_valid = 1'b0;
        io.b_mm_resolve = 4'b0010;
        io.b_mm_mispred = 1'b1;
        tick();
        io.b_mm_resolve = '0;
        io.b_mm_mispred = 1'b0;
        sx = 0;
        sy = 0;
        yr = '0;
        repeat (6) begin
            @(negedge clock);
            if (io.cdb_valid && io.out_dest_tag == 6'd20) sx++;
            if (io.cdb_valid && io.out_dest_tag == 6'd21) begin
                sy++;
                yr = io.out_result;
            end
            tick();
        end
        check("squash_killed", sx, 0);
        check("squash_other_seen", sy, 1);
        check("squash_other_result", yr, 42);
        drive(2'd0, 32'd9, 32'd9, 6'd22, 4'b0010);
        tick();
        io.in_valid = 1'b0;
        tick();
        io.b_mm_resolve = 4'b0010;
        io.b_mm_mispred = 1'b0;
        tick();
        io.b_mm_resolve = '0;
        lat = -1;
        for (int n = 2; n < 12 && lat < 0; n++) begin
            @(negedge clock);
            if (io.cdb_valid) begin
                lat = n;
                check("resolve_mask", io.out_b_mask, 0);
                check("resolve_result", io.out_result, 81);
                check("resolve_tag", io.out_dest_tag, 22);
            end
            tick();
        end
        check("resolve_latency", lat, N - 1);
        drive(2'd0, 32'd1, 32'd2, 6'd30, 4'b0);
        tick();
        drive(2'd1, 32'd3, 32'd4, 6'd31, 4'b0);
        tick();
        drive(2'd3, 32'd5, 32'd6, 6'd32, 4'b0);
        tick();
        io.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        @(negedge clock);
        check("midrst_cdb_valid", io.cdb_valid, 0);
        check("midrst_early", io.cdb_early_valid, 0);
        check("midrst_free", io.free, 1);
        tick();
        reset = 1'b0;
        run_op(2'd0, 32'h1234_5678, 32'd9, 6'd33, 32'hA3D7_0A38);
        repeat (400) begin
            io.in_valid = ($urandom_range(0, 9) < 7);
            io.in_func = 2'($urandom_range(0, 3));
            io.in_rs1 = pick();
            io.in_rs2 = pick();
            io.in_dest_tag = 6'($urandom);
            io.in_b_mask = ($urandom_range(0, 9) < 3) ? 4'($urandom) : 4'b0;
            io.cdb_gnt = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 2) begin
                io.b_mm_resolve = 4'b0001 << $urandom_range(0, 3);
                io.b_mm_mispred = 1'($urandom_range(0, 1));
            end else begin
                io.b_mm_resolve = '0;
                io.b_mm_mispred = 1'b0;
            end
            tick();
        end
        io.in_valid = 1'b0;
        io.b_mm_resolve = '0;
        io.b_mm_mispred = 1'b0;
        io.cdb_gnt = 1'b1;
        repeat (N + 3) tick();
        @(negedge clock);
        check("drain_empty", sb.size(), 0);
        check("drain_cdb_valid", io.cdb_valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_fu_pipe.md
# mult_fu_pipe

Parametrised pipelined integer multiply functional unit for the execute stage. It accepts one RV32M multiply per cycle from issue and carries branch masks through every stage, so that mispredicted work is squashed in flight. It raises an early CDB-valid one cycle before a result is ready and holds results under CDB backpressure. It replaces the fixed-depth multiplier and adds a configurable depth, stall handling and per-stage branch resolution.

## Interface
Parameters:
- XLEN, 32, operand/result width
- NUM_STAGES, 4, pipeline depth; must divide 2*XLEN; ≥2
- B_MASK_W, 4, branch mask width (one bit per in-flight branch)
- TAG_W, 6, physical register tag width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  issue presents a multiply
- in_rs1, in_rs2  in  XLEN  operands
- in_func  in  2  MUL=0, MULH=1, MULHSU=2, MULHU=3
- in_dest_tag  in  TAG_W  destination physical register
- in_b_mask  in  B_MASK_W  branches this op depends on
- free  out  1  op accepted this cycle if in_valid
- cdb_early_valid  out  1  stage NUM_STAGES-2 holds a live op
- cdb_valid  out  1  final stage holds a live result
- cdb_gnt  in  1  CDB takes the result this cycle
- out_result  out  XLEN  product (low or high half per func)
- out_dest_tag  out  TAG_W  tag of the final-stage op
- out_b_mask  out  B_MASK_W  current mask of the final-stage op
- b_mm_resolve  in  B_MASK_W  one-hot branch resolving this cycle
- b_mm_mispred  in  1  resolving branch mispredicted

## Operation
- Operands are extended to 2*XLEN bits: rs1 is signed for MUL, MULH and MULHSU; rs2 is signed for MUL and MULH; all other cases are zero-extended.
- Stage k adds rs1_ext × (rs2_ext chunk k) << (k·C), where C = 2*XLEN/NUM_STAGES. The accumulator, both operands and the function are carried forward.
- Result: MUL takes product[XLEN-1:0]; all other functions take product[2*XLEN-1:XLEN]. All arithmetic is modulo 2^(2*XLEN).
- Branch resolution applies to every stage register and to the incoming op:
  - If b_mm_mispred=1 and (mask & b_mm_resolve)≠0, the op is invalidated.
  - Otherwise, if b_mm_mispred=0, the b_mm_resolve bits are cleared from the mask.
- cdb_valid is masked combinationally: it reads 0 in a cycle where the final-stage op is being squashed.
- A squashed in_valid op is not accepted. free is still computed normally.
- Stall rule (default): stall = cdb_valid & ~cdb_gnt. When stalled, all stages hold their contents. free = ~stall.
- A grant with cdb_valid=0 is ignored.

## Timing
- Reset: all stage valids are 0. free=1; cdb_valid=0; cdb_early_valid=0; out_result, out_dest_tag and out_b_mask are 0.
- Latency: an op accepted at edge t has cdb_valid=1 in cycle t+NUM_STAGES-1 when no stall occurs (the first stage registers at accept).
- cdb_early_valid is high exactly one cycle before cdb_valid for an unstalled op.
- Throughput: 1 op per cycle. A result held under stall remains stable until granted.
- Simultaneous events:
  - Grant and squash of the final op in the same cycle: the squash wins and the grant is ignored.
  - A new op entering while the final stage drains: both happen.
  - Resolve while stalled: masks are still updated and squashes still take effect.
- Reset during operation: all in-flight ops are discarded at the next edge.

## Configuration
- MULT_BUBBLE_COLLAPSE_EN defined: each stage has its own ready signal. Stage k advances when stage k+1 is empty or advancing.
  - Bubbles upstream of a stalled final stage collapse.
  - free = stage0 empty or stage0 advancing.
- MULT_BUBBLE_COLLAPSE_EN undefined: the global stall rule above applies.

## Structure
- Shared package holds:
  - the MULT_FUNC enum;
  - MULT_STAGE_PACKET {valid, rs1_ext, rs2_ext, acc, func, dest_tag, b_mask};
  - the B_MASK typedef.
- Sub-module: mult_stage. It is one partial-product step with mask update and squash, instantiated NUM_STAGES times via generate.

## Test plan
- MUL 7 × -3, tag 5, cdb_gnt held 1 → cdb_valid in cycle t+3 with out_result=0xFFFFFFEB and tag 5. cdb_early_valid is seen at t+2.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH -1 × -1 → 0. MULHSU -1 × 0xFFFFFFFF → 0xFFFFFFFF.
- Back-to-back ops with cdb_gnt=0 for 3 cycles:
  - default build: free=0 for those 3 cycles, and results then emerge in order without loss;
  - bubble-collapse build: gap-separated ops compact while stalled.
- Op with mask 0b0010 in stage 1, then b_mm_resolve=0b0010 with mispred=1 → the op never raises cdb_valid. A concurrent op with mask 0b0001 is unaffected.
- Same op, resolve 0b0010 with mispred=0 → out_b_mask=0 at completion, and the result is delivered.
- Reset asserted with 3 ops in flight → cdb_valid=0 and free=1 in the following cycle. A new op afterwards completes at normal latency.
